// File: rtl/ccu_perf_monitor_if.sv
// Control and result-stream observation bundle for ccu_perf_monitor.
// master: the side that drives the CCU controls and the stream handshake.
// slave : the monitor, which only observes.
interface ccu_perf_monitor_if;
  logic        op_start;
  logic        op_abort;
  logic [31:0] iter_total;
  logic        rslt_tvalid;
  logic        rslt_tready;
  logic        rslt_tlast;

  modport master (output op_start, op_abort, iter_total, rslt_tvalid, rslt_tready, rslt_tlast);
  modport slave  (input  op_start, op_abort, iter_total, rslt_tvalid, rslt_tready, rslt_tlast);
endinterface

// File: rtl/ccu_perf_monitor.sv
// ccu_perf_monitor: operation/iteration progress and timing monitor for the
// CentralControlUnit. Feeds the write-only status bank of the CCU register
// file together with its update (wo_reg_en) and clear (wo_reg_rst) strobes.
// Optional: define CCU_PERF_MONITOR_STALL_CNT_EN to add the stall_cycles
// counter (result valid while not ready, counted in RUN).
module ccu_perf_monitor #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  ccu_perf_monitor_if.slave    ctl,
  output logic                 busy,
  output logic                 op_done,
  output logic                 wo_reg_en,
  output logic                 wo_reg_rst,
  output logic [CNT_WIDTH-1:0] operation_progress_rslt,
  output logic [CNT_WIDTH-1:0] operation_progress_iter,
  output logic [CNT_WIDTH-1:0] iteration_timer,
  output logic [CNT_WIDTH-1:0] iteration_latency,
  output logic [CNT_WIDTH-1:0] operation_timer,
  output logic [CNT_WIDTH-1:0] operation_latency
`ifdef CCU_PERF_MONITOR_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] iter_total_q;

  logic beat, last, in_run, start_acc, zero_iter, cmpl, finish, cnt_last;

  // Increment that either sticks at all-ones or wraps, depending on SATURATE.
  function automatic cnt_t inc(input cnt_t x);
    if (SATURATE && (&x)) return x;
    return x + cnt_t'(1);
  endfunction

  assign beat      = ctl.rslt_tvalid & ctl.rslt_tready;
  assign last      = beat & ctl.rslt_tlast;
  assign in_run    = (state_q == RUN);
  assign start_acc = ctl.op_start & ~in_run;
  assign zero_iter = (iter_total_q == 32'd0);
  // Compare on the unsaturated 33-bit sum so a saturated progress counter
  // can never alias onto the target count.
  assign cmpl      = last & (({1'b0, 32'(operation_progress_iter)} + 33'd1) == {1'b0, iter_total_q});
  // Abort outranks completion; a zero-length operation completes at once.
  assign finish    = in_run & ~ctl.op_abort & (zero_iter | cmpl);
  // Packet-end bookkeeping (and the wo_reg_en pulse) is skipped for a
  // zero-length operation, but kept on an aborting cycle.
  assign cnt_last  = in_run & last & ~zero_iter;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_acc) state_d = RUN;
      RUN: begin
        if (ctl.op_abort)          state_d = IDLE;
        else if (zero_iter | cmpl) state_d = DONE;
      end
      DONE:    state_d = start_acc ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Registered status outputs, strobes and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy                    <= 1'b0;
      op_done                 <= 1'b0;
      wo_reg_en               <= 1'b0;
      wo_reg_rst              <= 1'b0;
      iter_total_q            <= '0;
      operation_progress_rslt <= '0;
      operation_progress_iter <= '0;
      iteration_timer         <= '0;
      iteration_latency       <= '0;
      operation_timer         <= '0;
      operation_latency       <= '0;
`ifdef CCU_PERF_MONITOR_STALL_CNT_EN
      stall_cycles            <= '0;
`endif
    end else begin
      busy       <= (state_d == RUN);
      op_done    <= finish;
      wo_reg_en  <= cnt_last;
      wo_reg_rst <= start_acc;
      if (start_acc) begin
        iter_total_q            <= ctl.iter_total;
        operation_progress_rslt <= '0;
        operation_progress_iter <= '0;
        iteration_timer         <= '0;
        iteration_latency       <= '0;
        operation_timer         <= '0;
        operation_latency       <= '0;
`ifdef CCU_PERF_MONITOR_STALL_CNT_EN
        stall_cycles            <= '0;
`endif
      end else if (in_run) begin
        if (beat) operation_progress_rslt <= inc(operation_progress_rslt);
        if (cnt_last) begin
          operation_progress_iter <= inc(operation_progress_iter);
          iteration_latency       <= inc(iteration_timer);
        end
        // Timers freeze on the aborting cycle.
        if (!ctl.op_abort) begin
          operation_timer <= inc(operation_timer);
          iteration_timer <= cnt_last ? '0 : inc(iteration_timer);
        end
        if (finish) operation_latency <= inc(operation_timer);
`ifdef CCU_PERF_MONITOR_STALL_CNT_EN
        if (ctl.rslt_tvalid && !ctl.rslt_tready) stall_cycles <= inc(stall_cycles);
`endif
      end
    end
  end

endmodule
